// File: rtl/vga2_palette.sv
// vga2_palette: two-stage pixel resolve pipeline with a palette lookup,
// index-0 transparency and a per-line epoch-tagged Z-buffer.
//
// Ports
//   clock, reset_n          system clock, asynchronous active-low reset
//   palette_valid           pixel present (no backpressure)
//   palette_mode[4:0]       bit0 solid colour, bit1 index-0 transparent, bit2 z-test
//   palette_data[23:0]      RGB888 (solid) or palette index in [7:0]
//   palette_x[9:0]          destination column
//   palette_z[11:0]         depth, smaller is nearer
//   line_start              pulse that begins a new scanline (toggles epoch)
//   pal_wr_en/index/data    CPU palette write port
//   lb_write, lb_x, lb_rgb  line-buffer write strobe, column and colour
//   busy                    high while the Z-buffer clear sweep runs
module vga2_palette #(
    parameter int unsigned ZB_DEPTH = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        palette_valid,
    input  logic [4:0]  palette_mode,
    input  logic [23:0] palette_data,
    input  logic [9:0]  palette_x,
    input  logic [11:0] palette_z,
    input  logic        line_start,
    input  logic        pal_wr_en,
    input  logic [7:0]  pal_wr_index,
    input  logic [23:0] pal_wr_data,
    output logic        lb_write,
    output logic [9:0]  lb_x,
    output logic [23:0] lb_rgb,
    output logic        busy
);

    localparam int unsigned ZB_AW   = (ZB_DEPTH > 1) ? $clog2(ZB_DEPTH) : 1;
    localparam int unsigned ZB_SIZE = 1 << ZB_AW;
    localparam int unsigned Z_W     = 12;
    localparam int unsigned ZE_W    = Z_W + 1;
    localparam int unsigned X_W     = 10;
    localparam int unsigned RGB_W   = 24;
    localparam int unsigned IDX_W   = 8;
    localparam logic [Z_W-1:0] Z_FAR = 12'hFFF;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [ZB_AW-1:0]   cnt, cnt_nx;
    logic               epoch, epoch_nx;
    logic               busy_nx;

    // S1 pipeline registers
    logic               s1_valid;
    logic [2:0]         s1_mode;
    logic [RGB_W-1:0]   s1_data;
    logic [X_W-1:0]     s1_x;
    logic [Z_W-1:0]     s1_z;
    logic               s1_epoch;

    // RAMs and forwarding
    logic [RGB_W-1:0]   pal_mem [256];
    logic [RGB_W-1:0]   pal_rdata;
    logic [ZE_W-1:0]    zb_mem [ZB_SIZE];
    logic [ZE_W-1:0]    zb_rdata;
    logic               fwd_hit;
    logic [ZE_W-1:0]    fwd_data;

    logic               x_ok_c;
    logic [ZB_AW-1:0]   zb_raddr_c;
    logic               zb_we_c;
    logic [ZB_AW-1:0]   zb_waddr_c;
    logic [ZE_W-1:0]    zb_wdata_c;
    logic [ZE_W-1:0]    stored_c;
    logic [Z_W-1:0]     eff_z_c;
    logic               transparent_c;
    logic               z_pass_c;
    logic               pass_c;
    logic [RGB_W-1:0]   colour_c;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            epoch <= 1'b0;
            busy  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            epoch <= epoch_nx;
            busy  <= busy_nx;
        end
    end

    // Next state: clear sweep, then run with line_start toggling the epoch
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        epoch_nx = epoch;
        busy_nx  = busy;
        case (state)
            ST_CLEAR: begin
                cnt_nx = cnt + ZB_AW'(1);
                if (cnt == ZB_AW'(ZB_DEPTH - 1)) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                    busy_nx  = 1'b0;
                end
            end
            ST_RUN: begin
                if (line_start) begin
                    epoch_nx = ~epoch;
                end
            end
            default: begin
                state_nx = ST_CLEAR;
                busy_nx  = 1'b1;
            end
        endcase
    end

    assign x_ok_c     = (32'(palette_x) < ZB_DEPTH);
    assign zb_raddr_c = ZB_AW'(palette_x);

    // Palette RAM: read-first, so a same-cycle write returns the old colour
    always_ff @(posedge clock) begin
        if (pal_wr_en) begin
            pal_mem[pal_wr_index] <= pal_wr_data;
        end
        pal_rdata <= pal_mem[palette_data[IDX_W-1:0]];
    end

    // Z-buffer RAM
    always_ff @(posedge clock) begin
        if (zb_we_c) begin
            zb_mem[zb_waddr_c] <= zb_wdata_c;
        end
        zb_rdata <= zb_mem[zb_raddr_c];
    end

    // Resolve the S1 pixel; the forwarded entry covers a write landing on the read edge
    always_comb begin
        stored_c      = fwd_hit ? fwd_data : zb_rdata;
        eff_z_c       = (stored_c[ZE_W-1] == s1_epoch) ? stored_c[Z_W-1:0] : Z_FAR;
        transparent_c = !s1_mode[0] && s1_mode[1] && (s1_data[IDX_W-1:0] == '0);
        z_pass_c      = !s1_mode[2] || (s1_z < eff_z_c);
        pass_c        = s1_valid && !transparent_c && z_pass_c;
        colour_c      = s1_mode[0] ? s1_data : pal_rdata;
    end

    // Z-buffer write port: sweep in CLEAR, passing z-test pixels in RUN
    always_comb begin
        zb_we_c    = 1'b0;
        zb_waddr_c = ZB_AW'(s1_x);
        zb_wdata_c = {s1_epoch, s1_z};
        if (state == ST_CLEAR) begin
            zb_we_c    = 1'b1;
            zb_waddr_c = cnt;
            zb_wdata_c = {~epoch, Z_FAR};
        end else begin
            zb_we_c = pass_c && s1_mode[2];
        end
    end

    // Pipeline stages and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= '0;
            s1_data  <= '0;
            s1_x     <= '0;
            s1_z     <= '0;
            s1_epoch <= 1'b0;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
            lb_write <= 1'b0;
            lb_x     <= '0;
            lb_rgb   <= '0;
        end else begin
            s1_valid <= palette_valid && (state == ST_RUN) && x_ok_c;
            s1_mode  <= palette_mode[2:0];
            s1_data  <= palette_data;
            s1_x     <= palette_x;
            s1_z     <= palette_z;
            s1_epoch <= epoch_nx;
            fwd_hit  <= zb_we_c && (zb_waddr_c == zb_raddr_c);
            fwd_data <= zb_wdata_c;
            lb_write <= pass_c;
            if (pass_c) begin
                lb_x   <= s1_x;
                lb_rgb <= colour_c;
            end
        end
    end

endmodule

// File: doc/vga2_palette.md
VGA2_PALETTE -- requirements
Module: vga2_palette

Interface
REQ-001 The block SHALL have parameter ZB_DEPTH, default 1024, meaning Z-buffer entries per line; x values at or above ZB_DEPTH are dropped.
REQ-002 The block SHALL have port clock, input, 1, system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port palette_valid, input, 1, pixel present from the upstream read stage; there is no backpressure.
REQ-005 The block SHALL have port palette_mode, input, 5, mode: bit0 solid colour, bit1 index-0 transparent, bit2 z-test enable, bits4:3 unused.
REQ-006 The block SHALL have port palette_data, input, 24, RGB888 when bit0=1, otherwise an 8-bit index in [7:0].
REQ-007 The block SHALL have port palette_x, input, 10, destination pixel column.
REQ-008 The block SHALL have port palette_z, input, 12, pixel depth; a smaller value is nearer.
REQ-009 The block SHALL have port line_start, input, 1, single-cycle pulse that begins a new scanline.
REQ-010 The block SHALL have ports pal_wr_en (input, 1), pal_wr_index (input, 8) and pal_wr_data (input, 24), the CPU palette write port.
REQ-011 The block SHALL have port lb_write, output, 1, line-buffer write strobe.
REQ-012 The block SHALL have port lb_x, output, 10, line-buffer column.
REQ-013 The block SHALL have port lb_rgb, output, 24, line-buffer colour.
REQ-014 The block SHALL have port busy, output, 1, high while the Z-buffer clear sweep runs.

Function
REQ-015 The block SHALL hold a 256x24 palette RAM and a ZB_DEPTHx13 Z-buffer RAM; each Z-buffer entry is {epoch, z[11:0]}; both RAMs have a 1-cycle synchronous read.
REQ-016 The pipeline SHALL have 2 stages: S1 registers the pixel and issues the palette[data[7:0]] and zbuf[x] reads; S2 resolves the pixel and drives the outputs. Latency from palette_valid to lb_write is exactly 2 cycles.
REQ-017 The FSM SHALL have states CLEAR and RUN, and enters CLEAR from reset.
REQ-018 In CLEAR the block SHALL write {~epoch, 12'hFFF} to entries 0..ZB_DEPTH-1, one per cycle, hold busy=1 and drop incoming pixels; after the last entry it SHALL move to RUN and set busy=0.
REQ-019 In RUN, line_start SHALL toggle the 1-bit epoch register. Each pixel captures the epoch in force at S1 entry.
REQ-020 A line_start coincident with palette_valid SHALL apply the new epoch to that pixel.
REQ-021 A stored entry whose epoch differs from the pixel's epoch SHALL be treated as z=12'hFFF and empty.
REQ-022 Colour SHALL be palette_data[23:0] when mode bit0=1, otherwise the palette RAM output.
REQ-023 A pixel SHALL be dropped, with lb_write=0 and no Z-buffer write, when mode bit0=0, bit1=1 and index=0.
REQ-024 When mode bit2=1, the pixel SHALL pass only if its z is strictly less than the effective stored z (ties keep the existing pixel); on pass, zbuf[x] SHALL be written with {pixel epoch, z} in S2.
REQ-025 When mode bit2=0, the pixel SHALL always pass and the Z-buffer SHALL NOT be written.
REQ-026 When the S2 Z-buffer write targets the same x that S1 reads in that cycle, S1 SHALL forward the written value; back-to-back same-x pixels SHALL see each other's results.
REQ-027 A pal_wr_en write SHALL take effect from the next cycle; a read of the same index in the write cycle SHALL return the old colour.
REQ-028 A pal_wr_en write SHALL be accepted in both CLEAR and RUN.
REQ-029 Pixels with x >= ZB_DEPTH SHALL be dropped.
REQ-030 lb_write SHALL be high for one cycle per passing pixel; lb_x and lb_rgb SHALL be valid only while lb_write=1 and hold their last value otherwise.

Reset
REQ-031 While reset_n=0 the block SHALL drive lb_write=0, lb_x=0, lb_rgb=0, busy=1 and epoch=0, set the state to CLEAR with the sweep counter at 0, and invalidate both pipeline stages.
REQ-032 The palette RAM SHALL NOT be reset.
REQ-033 An assertion of reset_n mid-sweep or mid-line SHALL abort the sweep or line; the sweep restarts from entry 0 after release.

Verification
REQ-034 Scenario: release reset, then count cycles -> busy=1 for exactly 1024 cycles; a pixel offered during this window produces no lb_write; busy falls and RUN begins.
REQ-035 Scenario: write pal[5]=24'h123456, then send index 5, mode 0, x=7 -> 2 cycles later lb_write=1, lb_x=7, lb_rgb=24'h123456.
REQ-036 Scenario: after line_start, send z-test pixels at x=3 with z=100 then z=200, back to back -> only the first writes; then z=50 -> writes; then z=50 again -> tie, rejected.
REQ-037 Scenario: mode 3'b010 index 0 -> dropped; mode 3'b011 with data 24'h000000 -> written as black.
REQ-038 Scenario: z=10 at x=9, then line_start, then z=4000 at x=9 -> second pixel passes because the stale epoch entry reads as empty.
REQ-039 Scenario: pal_wr_en to index 8 in the same cycle index 8 enters S1 -> old colour output; the next pixel using index 8 -> new colour.
